// File: rtl/uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// uart_cmd_ctrl
//   Byte-level command sequencer between a UART RX/TX pair and the host-side
//   buffer/control of the compute core. Host frames:
//     WRITE = 0x01 ADDR LEN D0..D(LEN-1)  -> buffer writes, ack 0xAA
//     READ  = 0x02 ADDR LEN               -> LEN bytes streamed back, no ack
//     START = 0x03                        -> tpu_start pulse, ack 0xAA on done
//   Unknown opcodes answer 0xEE. A stalled frame (no byte for TIMEOUT_CYCLES)
//   is dropped silently. err_sticky latches any protocol problem until reset.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_rx_valid, i_rx_data     received byte strobe and data
//   i_tx_busy                 transmitter shifting
//   o_tx_start, o_tx_message  transmit request pulse and byte
//   o_mem_we, o_mem_re        buffer write / read strobes
//   o_mem_addr, o_mem_wdata   buffer address / write data
//   i_mem_rdata               buffer read data (valid 1 clk after o_mem_re)
//   o_tpu_start, i_tpu_done   compute start pulse / completion
//   o_busy                    high whenever not IDLE
//   o_err_sticky              protocol error flag
// ---------------------------------------------------------------------------
module uart_cmd_ctrl #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 270000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rx_valid,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_tx_busy,
  output logic              o_tx_start,
  output logic [DATA_W-1:0] o_tx_message,
  output logic              o_mem_we,
  output logic              o_mem_re,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_tpu_start,
  input  logic              i_tpu_done,
  output logic              o_busy,
  output logic              o_err_sticky
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DATA_W-1:0] OP_WRITE = DATA_W'(8'h01);
  localparam logic [DATA_W-1:0] OP_READ  = DATA_W'(8'h02);
  localparam logic [DATA_W-1:0] OP_START = DATA_W'(8'h03);
  localparam logic [DATA_W-1:0] RESP_OK  = DATA_W'(8'hAA);
  localparam logic [DATA_W-1:0] RESP_BAD = DATA_W'(8'hEE);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    GET_ADDR  = 4'd1,
    GET_LEN   = 4'd2,
    WR_DATA   = 4'd3,
    RD_FETCH  = 4'd4,
    RD_SEND   = 4'd5,
    RD_WAIT   = 4'd6,
    RUN       = 4'd7,
    RESP      = 4'd8,
    RESP_WAIT = 4'd9
  } state_t;

  state_t              r_state;
  logic                r_is_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_resp;
  logic                r_skip;    // one-clk hold-off (read latency / tx_busy rise)
  logic [TO_W-1:0]     r_to_cnt;
  logic                r_tx_start;
  logic [DATA_W-1:0]   r_tx_message;
  logic                r_mem_we;
  logic                r_mem_re;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_tpu_start;
  logic                r_busy;
  logic                r_err;

  logic w_in_frame;
  logic w_timeout;
  logic w_drop;

  assign w_in_frame = (r_state == GET_ADDR) || (r_state == GET_LEN) || (r_state == WR_DATA);
  // Aborts on the TIMEOUT_CYCLES-th consecutive clk without a byte.
  assign w_timeout  = w_in_frame && !i_rx_valid &&
                      (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  // Bytes arriving while reading, running or responding cannot be consumed.
  assign w_drop     = i_rx_valid && (r_state != IDLE) && !w_in_frame;

  assign o_tx_start   = r_tx_start;
  assign o_tx_message = r_tx_message;
  assign o_mem_we     = r_mem_we;
  assign o_mem_re     = r_mem_re;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_tpu_start  = r_tpu_start;
  assign o_busy       = r_busy;
  assign o_err_sticky = r_err;

  // Command FSM with registered outputs and inter-byte timeout counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_is_write   <= 1'b0;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_resp       <= '0;
      r_skip       <= 1'b0;
      r_to_cnt     <= '0;
      r_tx_start   <= 1'b0;
      r_tx_message <= '0;
      r_mem_we     <= 1'b0;
      r_mem_re     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_tpu_start  <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_tx_start  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_tpu_start <= 1'b0;

      if (!w_in_frame || i_rx_valid) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end

      if (w_drop) begin
        r_err <= 1'b1;
      end

      if (w_timeout) begin
        r_err   <= 1'b1;
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_rx_valid) begin
              r_busy <= 1'b1;
              if (i_rx_data == OP_WRITE) begin
                r_is_write <= 1'b1;
                r_state    <= GET_ADDR;
              end else if (i_rx_data == OP_READ) begin
                r_is_write <= 1'b0;
                r_state    <= GET_ADDR;
              end else if (i_rx_data == OP_START) begin
                r_tpu_start <= 1'b1;
                r_state     <= RUN;
              end else begin
                r_resp  <= RESP_BAD;
                r_err   <= 1'b1;
                r_state <= RESP;
              end
            end
          end
          GET_ADDR: begin
            if (i_rx_valid) begin
              r_addr  <= ADDR_W'(i_rx_data);
              r_state <= GET_LEN;
            end
          end
          GET_LEN: begin
            if (i_rx_valid) begin
              r_cnt <= i_rx_data;
              if (i_rx_data == DATA_W'(0)) begin
                r_resp  <= RESP_OK;
                r_state <= RESP;
              end else if (r_is_write) begin
                r_state <= WR_DATA;
              end else begin
                r_state <= RD_FETCH;
              end
            end
          end
          WR_DATA: begin
            if (i_rx_valid) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_addr;
              r_mem_wdata <= i_rx_data;
              r_addr      <= r_addr + ADDR_W'(1);
              r_cnt       <= r_cnt - DATA_W'(1);
              if (r_cnt == DATA_W'(1)) begin
                r_resp  <= RESP_OK;
                r_state <= RESP;
              end
            end
          end
          RD_FETCH: begin
            r_mem_re   <= 1'b1;
            r_mem_addr <= r_addr;
            r_skip     <= 1'b1;
            r_state    <= RD_SEND;
          end
          RD_SEND: begin
            // First clk here is the buffer read latency.
            if (r_skip) begin
              r_skip <= 1'b0;
            end else if (!i_tx_busy) begin
              r_tx_start   <= 1'b1;
              r_tx_message <= i_mem_rdata;
              r_skip       <= 1'b1;
              r_state      <= RD_WAIT;
            end
          end
          RD_WAIT: begin
            // tx_busy is not yet valid the clk right after tx_start.
            if (r_skip) begin
              r_skip <= 1'b0;
            end else if (!i_tx_busy) begin
              r_cnt  <= r_cnt - DATA_W'(1);
              r_addr <= r_addr + ADDR_W'(1);
              if (r_cnt == DATA_W'(1)) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state <= RD_FETCH;
              end
            end
          end
          RUN: begin
            if (i_tpu_done) begin
              r_resp  <= RESP_OK;
              r_state <= RESP;
            end
          end
          RESP: begin
            if (!i_tx_busy) begin
              r_tx_start   <= 1'b1;
              r_tx_message <= r_resp;
              r_skip       <= 1'b1;
              r_state      <= RESP_WAIT;
            end
          end
          RESP_WAIT: begin
            if (r_skip) begin
              r_skip <= 1'b0;
            end else if (!i_tx_busy) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_ctrl
//   Directed frames drive the sequencer; expected buffer writes and
//   transmitted bytes are queued as each frame is issued, and a monitor pops
//   and compares them whenever the DUT strobes mem_we or tx_start. Simple
//   behavioural models stand in for the buffer (1-clk read) and transmitter.
// ---------------------------------------------------------------------------
module tb_uart_cmd_ctrl;

  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_busy = 1'b0;
  logic       tx_start;
  logic [7:0] tx_message;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       tpu_start;
  logic       tpu_done;
  logic       busy;
  logic       err_sticky;

  int checks = 0;
  int errors = 0;
  int tpu_cnt = 0;

  logic [7:0]  exp_tx[$];
  logic [15:0] exp_wr[$];

  logic [7:0] mem [256];
  int         tx_left = 0;
  logic       busy_at_edge = 1'b0;

  uart_cmd_ctrl #(.DATA_W(8), .ADDR_W(8), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .i_tx_busy(tx_busy), .o_tx_start(tx_start), .o_tx_message(tx_message),
    .o_mem_we(mem_we), .o_mem_re(mem_re), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_tpu_start(tpu_start),
    .i_tpu_done(tpu_done), .o_busy(busy), .o_err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Buffer model: synchronous write, registered read.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // Transmitter model: busy for 8 clks after each tx_start.
  always @(posedge clk) begin
    busy_at_edge <= tx_busy;
    if (tx_start) begin
      tx_busy <= 1'b1;
      tx_left <= 8;
    end else if (tx_left > 0) begin
      tx_left <= tx_left - 1;
      if (tx_left == 1) tx_busy <= 1'b0;
    end
  end

  // Monitor: compare every strobe against the scoreboard queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we || mem_re) chk("we_re_exclusive", {31'd0, mem_we & mem_re}, 32'd0);
      if (tx_start) begin
        chk("tx_start_while_busy", {31'd0, busy_at_edge}, 32'd0);
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tx: got %0h expected none", tx_message);
        end else begin
          chk("tx_byte", {24'd0, tx_message}, {24'd0, exp_tx.pop_front()});
        end
      end
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got %0h=%0h expected none", mem_addr, mem_wdata);
        end else begin
          chk("mem_write", {16'd0, mem_addr, mem_wdata}, {16'd0, exp_wr.pop_front()});
        end
      end
      if (tpu_start) tpu_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_valid = 1'b1; rx_data = b;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("busy_low", {31'd0, busy}, 32'd0);
    chk("tx_drained", exp_tx.size(), 32'd0);
    chk("wr_drained", exp_wr.size(), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    exp_tx.delete(); exp_wr.delete();
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic pulse_done();
    @(negedge clk); tpu_done = 1'b1;
    @(negedge clk); tpu_done = 1'b0;
  endtask

  initial begin
    int t0;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tpu_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
    chk("rst_tpu_start", {31'd0, tpu_start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err_sticky}, 32'd0);
    rst_n = 1'b1;

    // WRITE 01 10 03 A1 B2 C3
    exp_wr.push_back(16'h10A1); exp_wr.push_back(16'h11B2); exp_wr.push_back(16'h12C3);
    exp_tx.push_back(8'hAA);
    send_byte(8'h01); send_byte(8'h10); send_byte(8'h03);
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
    wait_idle();
    chk("err_after_write", {31'd0, err_sticky}, 32'd0);

    // READ 02 10 03 streams back the bytes just written, no ack
    exp_tx.push_back(8'hA1); exp_tx.push_back(8'hB2); exp_tx.push_back(8'hC3);
    send_byte(8'h02); send_byte(8'h10); send_byte(8'h03);
    wait_idle();

    // WRITE with address wrap FF -> 00
    exp_wr.push_back(16'hFF11); exp_wr.push_back(16'h0022);
    exp_tx.push_back(8'hAA);
    send_byte(8'h01); send_byte(8'hFF); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22);
    wait_idle();

    // LEN=0 moves no data, ack only
    exp_tx.push_back(8'hAA);
    send_byte(8'h01); send_byte(8'h40); send_byte(8'h00);
    wait_idle();

    // START, done 50 clks later; ack only after done
    t0 = tpu_cnt;
    send_byte(8'h03);
    repeat (50) @(negedge clk);
    chk("busy_while_run", {31'd0, busy}, 32'd0 + 32'd1);
    exp_tx.push_back(8'hAA);
    pulse_done();
    wait_idle();
    chk("tpu_start_once", tpu_cnt - t0, 32'd1);
    chk("err_after_start", {31'd0, err_sticky}, 32'd0);

    // Timeout: gap of 38 clks is tolerated, then silence aborts
    send_byte(8'h01);
    repeat (36) @(negedge clk);
    send_byte(8'h20);
    repeat (38) @(negedge clk);
    chk("busy_before_timeout", {31'd0, busy}, 32'd1);
    chk("err_before_timeout", {31'd0, err_sticky}, 32'd0);
    repeat (3) @(negedge clk);
    chk("idle_after_timeout", {31'd0, busy}, 32'd0);
    chk("err_after_timeout", {31'd0, err_sticky}, 32'd1);
    chk("timeout_no_tx", exp_tx.size(), 32'd0);

    // Bad opcode answers EE, then a WRITE still works
    do_reset();
    chk("err_cleared_by_reset", {31'd0, err_sticky}, 32'd0);
    exp_tx.push_back(8'hEE);
    send_byte(8'h7E);
    wait_idle();
    chk("err_bad_opcode", {31'd0, err_sticky}, 32'd1);
    exp_wr.push_back(16'h305A); exp_tx.push_back(8'hAA);
    send_byte(8'h01); send_byte(8'h30); send_byte(8'h01); send_byte(8'h5A);
    wait_idle();

    // Byte arriving during RUN is dropped and flagged, run completes
    do_reset();
    send_byte(8'h03);
    repeat (5) @(negedge clk);
    chk("err_before_drop", {31'd0, err_sticky}, 32'd0);
    send_byte(8'h55);
    chk("err_dropped_byte", {31'd0, err_sticky}, 32'd1);
    chk("busy_after_drop", {31'd0, busy}, 32'd1);
    exp_tx.push_back(8'hAA);
    pulse_done();
    wait_idle();

    // Reset mid-READ: outputs drop at once, nothing transmitted
    do_reset();
    send_byte(8'h02); send_byte(8'h10); send_byte(8'h03);
    @(posedge clk); #1;
    chk("read_fetch_re", {31'd0, mem_re}, 32'd1);
    chk("read_fetch_addr", {24'd0, mem_addr}, 32'h10);
    rst_n = 1'b0; #1;
    chk("midrst_mem_re", {31'd0, mem_re}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("midrst_addr", {24'd0, mem_addr}, 32'd0);
    repeat (20) @(negedge clk);
    chk("midrst_no_tx", {31'd0, tx_start}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
